latch_bank_ctrl: RTL and testbench
==================================

Name: latch_bank_ctrl

Overview:
- Sequencing and arbitration controller for a bank of N cross-coupled NOR set/reset latch cells. Each cell has inputs s and r and output q.
- Two requesters share the bank through valid/ready handshakes.
- The block converts each write into a timed set or reset pulse, followed by a settle window. It samples q for reads and for write read-back.
- Guarantees that no cell ever sees s=r=1 and that at most one cell is driven at a time.

Parameters:
- N_CELLS, 8: number of latch cells in the bank.
- ADDR_W, 3: address width. Must satisfy 2**ADDR_W >= N_CELLS.
- PULSE_CYC, 2: clock cycles s or r is held high per write. Must be >= 1.
- HOLD_CYC, 1: cycles with s=r=0 after the pulse, before sampling. Must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 request present.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  ADDR_W  cell index.
- req0_wdata  in  1  value to store (1=set, 0=reset).
- req0_ready  out  1  request accepted this cycle.
- req0_rvalid  out  1  one-cycle response strobe.
- req0_rdata  out  1  sampled q of the addressed cell.
- req1_*  same set as req0_*, for requester 1.
- err  out  1  write read-back mismatch, qualified by the rvalid of the owning requester.
- cell_s  out  N_CELLS  per-cell set drive.
- cell_r  out  N_CELLS  per-cell reset drive.
- cell_q  in  N_CELLS  per-cell latch outputs.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
  - While rst is high, on the next edge: FSM=IDLE; cell_s=0; cell_r=0; all ready=0, rvalid=0, rdata=0; err=0; last_grant=1, so requester 0 wins the first tie.
  - Latch contents are not touched by reset.
- Handshake: a requester holds valid and a stable payload until ready. Transfer occurs on valid&ready.
  - ready is combinational and is high only in IDLE for the arbitration winner.
  - A requester must not drop valid before ready.
- Arbitration: two-way round-robin.
  - If both are valid in IDLE, grant the requester not granted last.
  - A single valid requester is granted immediately.
  - last_grant updates on acceptance.
- FSM states: IDLE, PULSE, HOLD, SAMPLE, RESP.
  - IDLE: on accept, latch owner, we, addr and wdata. Write goes to PULSE, read goes to SAMPLE.
  - PULSE: drive cell_s[addr] if wdata=1, else cell_r[addr], for PULSE_CYC cycles. Then go to HOLD.
  - HOLD: all s/r low for HOLD_CYC cycles. Then go to SAMPLE.
  - SAMPLE: register cell_q[addr] into rdata. Go to RESP.
  - RESP: owner's rvalid=1 for exactly one cycle with rdata/err. Go to IDLE.
- Latency, with accept at cycle T:
  - Read: rvalid at T+2. Next accept possible at T+3.
  - Write: rvalid at T+PULSE_CYC+HOLD_CYC+2 (T+5 with defaults).
- Outputs: cell_s/cell_r are registered. They are asserted only in PULSE and only at bit addr; every other bit is 0.
- Invariant: (cell_s & cell_r)==0 every cycle.
- Out-of-range address (addr >= N_CELLS):
  - Write: no pulse, still completes with normal timing.
  - Read: rdata=0.
- Non-owner signals: the non-owner's ready and rvalid stay 0 throughout a transaction. The non-owner's rdata holds its last value.
- Reset mid-operation: the pulse aborts within one cycle. No rvalid is issued for the aborted transaction. The cell may hold either value.
- Counters: one down-counter of width $clog2(max(PULSE_CYC,HOLD_CYC))+1. Loaded on entry to PULSE and to HOLD.

Optional Feature:
- Macro: LATCH_BANK_CTRL_WRITE_VERIFY_EN.
- Defined:
  - At SAMPLE of a write, compare cell_q[addr] with wdata. On mismatch, retry the PULSE/HOLD/SAMPLE sequence exactly once.
  - If the retry also mismatches, err=1 with rvalid in RESP.
  - A successful retry gives err=0, with latency extended by PULSE_CYC+HOLD_CYC+1.
- Undefined: no compare and no retry. err tied 0. Write rdata still returns the sampled q.

Decomposition:
- Package latch_ctrl_pkg: FSM state encoding constants (IDLE..RESP), requester-ID constants (REQ0=0, REQ1=1), and a counter-width function.
- One sub-module, rr_arb2: two-way round-robin arbiter.
  - Inputs: valid[1:0], enable (FSM==IDLE).
  - Outputs: grant[1:0] one-hot, plus the last_grant register.
- FSM, counter and cell drive stay in latch_bank_ctrl.

Test Plan:
- Reset, then req0 write addr=3 wdata=1 (bench models the NOR latch cell) -> cell_s[3]=1 for 2 cycles, then 1 hold cycle; req0_rvalid at T+5 with rdata=1; cell_q[3]=1.
- Read addr=3 from req1 -> req1_rvalid at T+2 with rdata=1; cell_s=cell_r=0 throughout.
- Both valid in the same cycle after reset -> req0 granted first, req1 granted on the next IDLE; grants alternate while both stay valid.
- rst asserted during PULSE of a write to addr=5 -> cell_s/cell_r all 0 the cycle after rst; no rvalid; the next request is accepted normally.
- Write addr=9 with N_CELLS=8 -> no s/r activity, rvalid at T+5. Over random traffic, assert that cell_s&cell_r is never nonzero and that at most one bit is active.
- With LATCH_BANK_CTRL_WRITE_VERIFY_EN, cell 2 model stuck at 0, write 1 -> two pulse sequences, then rvalid with err=1. With the macro undefined -> single pulse, err=0, rdata=0.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch bank controller: FSM state encoding,
// requester identifiers and the pulse/hold counter width helper.
package latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        HOLD   = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // One down-counter serves both timed phases, so size it for the longer one.
    function automatic int cnt_width(input int pulse_cyc, input int hold_cyc);
        int longest;
        longest = (pulse_cyc > hold_cyc) ? pulse_cyc : hold_cyc;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A tie goes to the requester not granted last;
// last_grant doubles as the owner of the transaction in flight.
module rr_arb2
    import latch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant selection: single requester wins outright, a tie alternates.
    always_comb begin
        grant = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else if (valid == 2'b11) begin
            grant = (last_grant_q == REQ0) ? 2'b10 : 2'b01;
        end else if (valid[0]) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // Every grant is an acceptance, so the history moves on any grant.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = REQ0;
        end else if (grant[1]) begin
            last_grant_d = REQ1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Grant history register; REQ1 at reset so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/latch_bank_ctrl.sv
// Sequencer/arbiter for a bank of NOR S/R latch cells: timed set/reset pulses,
// settle window and q sampling. Optional macro: LATCH_BANK_CTRL_WRITE_VERIFY_EN.
module latch_bank_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int N_CELLS   = 8,
    parameter int ADDR_W    = 3,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req0_we,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic               req0_wdata,
    output logic               req0_ready,
    output logic               req0_rvalid,
    output logic               req0_rdata,
    input  logic               req1_valid,
    input  logic               req1_we,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic               req1_wdata,
    output logic               req1_ready,
    output logic               req1_rvalid,
    output logic               req1_rdata,
    output logic               err,
    output logic [N_CELLS-1:0] cell_s,
    output logic [N_CELLS-1:0] cell_r,
    input  logic [N_CELLS-1:0] cell_q
);

    localparam int              CNT_W    = cnt_width(PULSE_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wdata_q, wdata_d;
    logic [N_CELLS-1:0]  cell_s_q, cell_s_d;
    logic [N_CELLS-1:0]  cell_r_q, cell_r_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [1:0]          rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [1:0]          grant;
    logic                owner;
    logic                arb_en;
    logic [N_CELLS-1:0]  drive_mask;
    logic                q_sel;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
    logic                we_q, we_d;
    logic                retry_q, retry_d;
    logic                addr_ok;
    logic                mismatch;
`endif

    assign arb_en = (state_q == IDLE) && !rst;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .valid      ({req1_valid, req0_valid}),
        .enable     (arb_en),
        .grant      (grant),
        .last_grant (owner)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Address decode: out-of-range addresses select nothing, so they read 0
    // and never drive a cell.
    always_comb begin
        q_sel      = 1'b0;
        drive_mask = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            q_sel         = (addr_q == ADDR_W'(i)) ? cell_q[i] : q_sel;
            drive_mask[i] = (addr_d == ADDR_W'(i));
        end
    end

`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
    assign addr_ok  = (int'(addr_q) < N_CELLS);
    assign mismatch = we_q && addr_ok && (q_sel != wdata_q);
`endif

    // Next-state, payload capture and phase counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
        we_d    = we_q;
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    addr_d  = grant[1] ? req1_addr  : req0_addr;
                    wdata_d = grant[1] ? req1_wdata : req0_wdata;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
                    we_d    = grant[1] ? req1_we : req0_we;
                    retry_d = 1'b0;
`endif
                    if (grant[1] ? req1_we : req0_we) begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LD;
                    end else begin
                        state_d = SAMPLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            SAMPLE: begin
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
                // A failed read-back earns exactly one more pulse sequence.
                if (mismatch && !retry_q) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                    retry_d = 1'b1;
                end else begin
                    state_d = RESP;
                end
`else
                state_d = RESP;
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values, derived from the next state so the flops line up
    // with the state they belong to; s and r are mutually exclusive by build.
    always_comb begin
        cell_s_d = '0;
        cell_r_d = '0;
        if (state_d == PULSE) begin
            if (wdata_d) begin
                cell_s_d = drive_mask;
            end else begin
                cell_r_d = drive_mask;
            end
        end else begin
            cell_s_d = '0;
            cell_r_d = '0;
        end

        rvalid_d = (state_d == RESP) ? ((owner == REQ1) ? 2'b10 : 2'b01) : 2'b00;

        rdata_d = rdata_q;
        if (state_q == SAMPLE) begin
            if (owner == REQ1) begin
                rdata_d[1] = q_sel;
            end else begin
                rdata_d[0] = q_sel;
            end
        end else begin
            rdata_d = rdata_q;
        end

        err_d = 1'b0;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
        if ((state_q == SAMPLE) && mismatch && retry_q) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end
`endif
    end

    // State and registered outputs; latch contents are outside this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            addr_q   <= '0;
            wdata_q  <= 1'b0;
            cell_s_q <= '0;
            cell_r_q <= '0;
            rvalid_q <= 2'b00;
            rdata_q  <= 2'b00;
            err_q    <= 1'b0;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
            we_q     <= 1'b0;
            retry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cell_s_q <= cell_s_d;
            cell_r_q <= cell_r_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
            we_q     <= we_d;
            retry_q  <= retry_d;
`endif
        end
    end

    assign cell_s      = cell_s_q;
    assign cell_r      = cell_r_q;
    assign req0_rvalid = rvalid_q[0];
    assign req1_rvalid = rvalid_q[1];
    assign req0_rdata  = rdata_q[0];
    assign req1_rdata  = rdata_q[1];
    assign err         = err_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Scoreboard bench for latch_bank_ctrl: NOR-latch cell model, per-requester
// expectation queues filled at acceptance and drained by a response monitor.
module tb_latch_bank_ctrl;

    localparam int N  = 8;
    localparam int AW = 4;
    localparam int P  = 2;
    localparam int H  = 1;

    typedef struct {
        bit           rdata;
        bit           err;
        int           due;
        int           s_cnt;
        int           r_cnt;
        logic [N-1:0] s_or;
        logic [N-1:0] r_or;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_we, req0_wdata, req0_ready, req0_rvalid, req0_rdata;
    logic [AW-1:0] req0_addr;
    logic          req1_valid, req1_we, req1_wdata, req1_ready, req1_rvalid, req1_rdata;
    logic [AW-1:0] req1_addr;
    logic          err;
    logic [N-1:0]  cell_s, cell_r, cell_q;

    logic [N-1:0]  lq = '0;
    logic          stuck = 1'b0;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    bit            mem [N];
    int            glog[$];
    exp_t          q0[$];
    exp_t          q1[$];
    int            s_cnt = 0;
    int            r_cnt = 0;
    logic [N-1:0]  s_or = '0;
    logic [N-1:0]  r_or = '0;

    latch_bank_ctrl #(.N_CELLS(N), .ADDR_W(AW), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .err(err), .cell_s(cell_s), .cell_r(cell_r), .cell_q(cell_q)
    );

    always #5 clk = ~clk;

    // NOR latch cells: s sets, r resets, otherwise hold; cell 2 may be stuck at 0.
    assign cell_q = lq;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (stuck && i == 2)  lq[i] <= 1'b0;
            else if (cell_s[i])   lq[i] <= 1'b1;
            else if (cell_r[i])   lq[i] <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the bank should contain and what the response must be.
    function automatic exp_t model(input bit we, input int addr, input bit wd);
        exp_t e;
        bit   inr   = (addr < N);
        bit   stk   = stuck && (addr == 2);
        int   tries = 1;
        e.err = 1'b0; e.s_cnt = 0; e.r_cnt = 0; e.s_or = '0; e.r_or = '0;
        if (!we) begin
            e.rdata = inr ? mem[addr] : 1'b0;
            e.due   = cyc + 2;
        end else begin
            if (inr) mem[addr] = stk ? 1'b0 : wd;
`ifdef LATCH_BANK_CTRL_WRITE_VERIFY_EN
            if (inr && stk && wd) begin
                tries = 2;
                e.err = 1'b1;
            end
`endif
            e.rdata = inr ? mem[addr] : 1'b0;
            e.due   = cyc + tries * (P + H + 1) + 1;
            if (inr && wd) begin
                e.s_cnt = tries * P;
                e.s_or  = N'(1) << addr;
            end else if (inr) begin
                e.r_cnt = tries * P;
                e.r_or  = N'(1) << addr;
            end
        end
        return e;
    endfunction

    // Acceptance recorder: push the expected response at the transfer edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                q0.push_back(model(req0_we, int'(req0_addr), req0_wdata));
                glog.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                q1.push_back(model(req1_we, int'(req1_addr), req1_wdata));
                glog.push_back(1);
            end
        end
        cyc = cyc + 1;
    end

    task automatic check_resp(input int p);
        exp_t e;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            chk(p == 0 ? "rvalid0_unexpected" : "rvalid1_unexpected", 1, 0);
        end else begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk(p == 0 ? "rdata0" : "rdata1", p == 0 ? req0_rdata : req1_rdata, e.rdata);
            chk("err", err, e.err);
            chk("latency", cyc, e.due);
            chk("s_cycles", s_cnt, e.s_cnt);
            chk("r_cycles", r_cnt, e.r_cnt);
            chk("s_bits", int'(s_or), int'(e.s_or));
            chk("r_bits", int'(r_or), int'(e.r_or));
        end
        s_cnt = 0; r_cnt = 0; s_or = '0; r_or = '0;
    endtask

    // Response monitor plus per-cycle drive invariants.
    always @(negedge clk) begin
        if (rst) begin
            s_cnt = 0; r_cnt = 0; s_or = '0; r_or = '0;
        end else begin
            chk("sr_overlap", int'((cell_s & cell_r) != '0), 0);
            chk("one_cell_driven", int'($countones(cell_s | cell_r) > 1), 0);
            chk("ready_onehot", int'(req0_ready && req1_ready), 0);
            if (q0.size() + q1.size() > 0)
                chk("ready_busy", int'(req0_ready || req1_ready), 0);
            if (err && !req0_rvalid && !req1_rvalid)
                chk("err_unqualified", 1, 0);
            if (cell_s != '0) begin s_cnt++; s_or |= cell_s; end
            if (cell_r != '0) begin r_cnt++; r_or |= cell_r; end
            if (req0_rvalid) check_resp(0);
            if (req1_rvalid) check_resp(1);
        end
    end

    task automatic send(input int p, input bit we, input int addr, input bit wd);
        bit ok = 1'b0;
        @(negedge clk);
        if (p == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = AW'(addr); req0_wdata = wd;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = AW'(addr); req1_wdata = wd;
        end
        for (int k = 0; k < 300 && !ok; k++) begin
            #1;
            if ((p == 0) ? req0_ready : req1_ready) ok = 1'b1;
            else @(negedge clk);
        end
        chk("accept_timeout", ok, 1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) done = 1'b1;
        end
        chk("resp_timeout", done, 1);
    endtask

    task automatic rand_traffic(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(p, 1'($urandom), int'($urandom_range(0, 10)), 1'($urandom));
        end
    endtask

    initial begin
        int exp_order [4] = '{0, 1, 0, 1};
        for (int i = 0; i < N; i++) mem[i] = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'd1; req0_wdata = 1'b1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'd2; req1_wdata = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_cell_s", int'(cell_s), 0);
        chk("rst_cell_r", int'(cell_r), 0);
        chk("rst_rvalid", int'({req1_rvalid, req0_rvalid}), 0);
        chk("rst_rdata", int'({req1_rdata, req0_rdata}), 0);
        chk("rst_err", err, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        send(0, 1'b1, 3, 1'b1);
        wait_idle();
        chk("latch3_set", lq[3], 1);
        send(1, 1'b0, 3, 1'b0);
        wait_idle();

        glog.delete();
        fork
            begin send(0, 1'b0, 1, 1'b0); send(0, 1'b0, 3, 1'b0); end
            begin send(1, 1'b0, 2, 1'b0); send(1, 1'b0, 4, 1'b0); end
        join
        wait_idle();
        chk("arb_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("arb_order", glog[i], exp_order[i]);

        // Abort a write in the middle of its pulse.
        send(0, 1'b1, 5, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        q0.delete(); q1.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_cell_s", int'(cell_s), 0);
        chk("abort_cell_r", int'(cell_r), 0);
        rst = 1'b0;
        send(1, 1'b1, 5, 1'b0);
        wait_idle();
        send(0, 1'b0, 5, 1'b0);
        wait_idle();

        send(0, 1'b1, 9, 1'b1);
        wait_idle();
        send(1, 1'b0, 9, 1'b0);
        wait_idle();

        stuck = 1'b1;
        send(1, 1'b1, 2, 1'b1);
        wait_idle();
        stuck = 1'b0;

        fork
            rand_traffic(0, 25);
            rand_traffic(1, 25);
        join
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
